pipe_stage_skid: RTL and testbench

- Parametrised inter-stage pipeline register for the 5-stage MIPS core (E/M, M/W and later stages).
- Adds valid/ready backpressure with a one-entry skid buffer, so multi-cycle units (HI/LO, bus stalls) can throttle downstream stages without a combinational ready path.
- Carries the PC, exception code and branch-delay flag beside an opaque payload.
- Supports bubble flush and exception flush; an exception flush redirects the PC to the handler vector.

---
 rtl/core_pkg.sv | 29 ++
 rtl/pipe_stage_skid_slot.sv | 76 +++++++
 rtl/pipe_stage_skid.sv | 131 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: reset/exception vectors,
// exception codes and the pipeline slot bundle.
package core_pkg;

    localparam int PC_W   = 32;
    localparam int DATA_W = 128;
    localparam int EXC_W  = 5;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_PC   = 32'h0000_4180;

    typedef enum logic [EXC_W-1:0] {
        EXC_NONE    = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    typedef struct packed {
        logic              valid;
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
        logic [EXC_W-1:0]  exc;
        logic              bd;
    } slot_t;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One pipeline slot: clear wins over load; a clear keeps
// caller-chosen pc/bd so bubbles can carry EPC information.
module pipe_slot #(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic [PC_W-1:0]   clr_pc,
    input  logic              clr_bd,
    input  logic              load,
    input  logic [PC_W-1:0]   ld_pc,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [EXC_W-1:0]  ld_exc,
    input  logic              ld_bd,
    output logic              q_valid,
    output logic [PC_W-1:0]   q_pc,
    output logic [DATA_W-1:0] q_data,
    output logic [EXC_W-1:0]  q_exc,
    output logic              q_bd
);
    import core_pkg::*;

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic              bd_q, bd_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        data_d  = data_q;
        exc_d   = exc_q;
        bd_d    = bd_q;
        if (clr) begin
            valid_d = 1'b0;
            pc_d    = clr_pc;
            data_d  = '0;
            exc_d   = EXC_W'(EXC_NONE);
            bd_d    = clr_bd;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = ld_pc;
            data_d  = ld_data;
            exc_d   = ld_exc;
            bd_d    = ld_bd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= RESET_PC;
            data_q  <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
            bd_q    <= bd_d;
        end
    end

    assign q_valid = valid_q;
    assign q_pc    = pc_q;
    assign q_data  = data_q;
    assign q_exc   = exc_q;
    assign q_bd    = bd_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage register with a one-entry skid buffer; in_ready
// comes straight from the skid valid flop.
module pipe_stage_skid #(
    parameter int              DATA_W   = 128,
    parameter int              PC_W     = 32,
    parameter int              EXC_W    = 5,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] EXC_PC   = PC_W'(32'h0000_4180)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,
    input  logic              flush,
    input  logic              exc_req,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd
);
    import core_pkg::*;

    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [EXC_W-1:0]  skid_exc;
    logic              skid_bd;

    logic              acc, adv;
    logic              main_clr, main_load, main_from_skid;
    logic [PC_W-1:0]   main_clr_pc;
    logic              main_clr_bd;
    logic              skid_clr, skid_load;
    logic [PC_W-1:0]   main_ld_pc;
    logic [DATA_W-1:0] main_ld_data;
    logic [EXC_W-1:0]  main_ld_exc;
    logic              main_ld_bd;

    assign in_ready = ~skid_valid;
    assign acc      = in_valid & in_ready;
    assign adv      = ~out_valid | out_ready;

    always_comb begin
        main_clr       = 1'b0;
        main_clr_pc    = in_pc;
        main_clr_bd    = in_bd;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_clr       = 1'b0;
        skid_load      = 1'b0;
        if (exc_req) begin
            main_clr    = 1'b1;
            main_clr_pc = EXC_PC;
            main_clr_bd = 1'b0;
            skid_clr    = 1'b1;
        end else if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (skid_valid) begin
            if (out_ready) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                skid_clr       = 1'b1;
            end
        end else if (adv) begin
            // Idle bubbles keep tracking the upstream pc/bd
            if (acc) main_load = 1'b1;
            else     main_clr  = 1'b1;
        end else if (acc) begin
            skid_load = 1'b1;
        end
    end

    assign main_ld_pc   = main_from_skid ? skid_pc   : in_pc;
    assign main_ld_data = main_from_skid ? skid_data : in_data;
    assign main_ld_exc  = main_from_skid ? skid_exc  : in_exc;
    assign main_ld_bd   = main_from_skid ? skid_bd   : in_bd;

    pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .EXC_W   (EXC_W),
        .RESET_PC(RESET_PC)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .clr    (main_clr),
        .clr_pc (main_clr_pc),
        .clr_bd (main_clr_bd),
        .load   (main_load),
        .ld_pc  (main_ld_pc),
        .ld_data(main_ld_data),
        .ld_exc (main_ld_exc),
        .ld_bd  (main_ld_bd),
        .q_valid(out_valid),
        .q_pc   (out_pc),
        .q_data (out_data),
        .q_exc  (out_exc),
        .q_bd   (out_bd)
    );

    pipe_slot #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .EXC_W   (EXC_W),
        .RESET_PC('0)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .clr    (skid_clr),
        .clr_pc ('0),
        .clr_bd (1'b0),
        .load   (skid_load),
        .ld_pc  (in_pc),
        .ld_data(in_data),
        .ld_exc (in_exc),
        .ld_bd  (in_bd),
        .q_valid(skid_valid),
        .q_pc   (skid_pc),
        .q_data (skid_data),
        .q_exc  (skid_exc),
        .q_bd   (skid_bd)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a negedge monitor checks
// delivered entries against a scoreboard of accepted inputs.
module tb_pipe_stage_skid;
    import core_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [127:0]      in_data;
    logic [4:0]        in_exc;
    logic              in_bd;
    logic              flush;
    logic              exc_req;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [127:0]      out_data;
    logic [4:0]        out_exc;
    logic              out_bd;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    slot_t sb[$];

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_data  (in_data),
        .in_exc   (in_exc),
        .in_bd    (in_bd),
        .flush    (flush),
        .exc_req  (exc_req),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_data (out_data),
        .out_exc  (out_exc),
        .out_bd   (out_bd)
    );

    function automatic logic [127:0] data_of(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'h5a5a_5a5a, 32'h1234_0000 | pc};
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [31:0] pc,
                       input logic [4:0] exc, input logic bd);
        in_valid = v;
        in_pc    = pc;
        in_data  = data_of(pc);
        in_exc   = exc;
        in_bd    = bd;
    endtask

    // Handshakes observed mid-cycle, where all signals are stable
    always @(negedge clk) begin
        slot_t e;
        if (reset || exc_req || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected: got pc %0h want none",
                             out_pc);
                end else begin
                    e = sb.pop_front();
                    pops++;
                    chk("mon_pc", 128'(out_pc), 128'(e.pc));
                    chk("mon_data", out_data, e.data);
                    chk("mon_exc", 128'(out_exc), 128'(e.exc));
                    chk("mon_bd", 128'(out_bd), 128'(e.bd));
                end
            end
            if (in_valid && in_ready) begin
                e.valid = 1'b1;
                e.pc    = in_pc;
                e.data  = data_of(in_pc);
                e.exc   = in_exc;
                e.bd    = in_bd;
                sb.push_back(e);
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        exc_req = 1'b0;
        out_ready = 1'b1;
        drv(1'b0, 32'h0, 5'd0, 1'b0);
        step();
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_pc", 128'(out_pc), 128'(32'h3000));
        chk("rst_ready", 128'(in_ready), 128'(1));
        chk("rst_data", out_data, 128'(0));

        // 1: first acceptance, one cycle latency
        reset = 1'b0;
        drv(1'b1, 32'h3004, 5'(EXC_SYSCALL), 1'b1);
        step();
        chk("t1_valid", 128'(out_valid), 128'(1));
        chk("t1_pc", 128'(out_pc), 128'(32'h3004));
        chk("t1_exc", 128'(out_exc), 128'(8));

        // 2: streaming
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h3000 + 32'(4 * i), 5'(i), i[0]);
            step();
            chk("t2_pc", 128'(out_pc), 128'(32'h3000 + 32'(4 * i)));
            chk("t2_ready", 128'(in_ready), 128'(1));
        end
        drv(1'b0, 32'h3100, 5'd0, 1'b0);
        step();
        chk("t2_drain", 128'(out_valid), 128'(0));

        // 3: backpressure into FULL
        out_ready = 1'b0;
        drv(1'b1, 32'h3020, 5'(EXC_OV), 1'b0);
        step();
        chk("t3_one_pc", 128'(out_pc), 128'(32'h3020));
        chk("t3_one_rdy", 128'(in_ready), 128'(1));
        drv(1'b1, 32'h3024, 5'(EXC_RI), 1'b1);
        step();
        chk("t3_full_rdy", 128'(in_ready), 128'(0));
        chk("t3_full_pc", 128'(out_pc), 128'(32'h3020));
        drv(1'b1, 32'h3028, 5'(EXC_ADEL), 1'b0);
        step();
        chk("t3_hold_pc", 128'(out_pc), 128'(32'h3020));
        chk("t3_hold_rdy", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        step();
        chk("t3_drain1", 128'(out_pc), 128'(32'h3024));
        chk("t3_drain1_rdy", 128'(in_ready), 128'(1));
        step();
        chk("t3_third", 128'(out_pc), 128'(32'h3028));
        chk("t3_third_v", 128'(out_valid), 128'(1));
        drv(1'b0, 32'h3200, 5'd0, 1'b0);
        step();
        chk("t3_empty", 128'(out_valid), 128'(0));

        // 4: exception in FULL
        out_ready = 1'b0;
        drv(1'b1, 32'h3030, 5'd0, 1'b0);
        step();
        drv(1'b1, 32'h3034, 5'd0, 1'b0);
        step();
        chk("t4_full", 128'(in_ready), 128'(0));
        drv(1'b1, 32'h3038, 5'(EXC_ADES), 1'b0);
        exc_req = 1'b1;
        step();
        chk("t4_valid", 128'(out_valid), 128'(0));
        chk("t4_pc", 128'(out_pc), 128'(32'h4180));
        chk("t4_exc", 128'(out_exc), 128'(0));
        chk("t4_ready", 128'(in_ready), 128'(1));
        exc_req = 1'b0;
        out_ready = 1'b1;
        drv(1'b0, 32'h3300, 5'd0, 1'b0);
        step();
        chk("t4_gone", 128'(out_valid), 128'(0));

        // 5: flush keeps killed pc/bd
        out_ready = 1'b0;
        drv(1'b1, 32'h3040, 5'd0, 1'b0);
        step();
        drv(1'b1, 32'h3010, 5'd0, 1'b1);
        flush = 1'b1;
        step();
        chk("t5_valid", 128'(out_valid), 128'(0));
        chk("t5_data", out_data, 128'(0));
        chk("t5_pc", 128'(out_pc), 128'(32'h3010));
        chk("t5_bd", 128'(out_bd), 128'(1));
        chk("t5_ready", 128'(in_ready), 128'(1));

        // 6: flush with exc_req, then reset mid-FULL
        exc_req = 1'b1;
        step();
        chk("t6_pc", 128'(out_pc), 128'(32'h4180));
        chk("t6_bd", 128'(out_bd), 128'(0));
        flush = 1'b0;
        exc_req = 1'b0;
        drv(1'b1, 32'h3050, 5'd0, 1'b0);
        step();
        drv(1'b1, 32'h3054, 5'd0, 1'b0);
        step();
        chk("t6_full", 128'(in_ready), 128'(0));
        reset = 1'b1;
        step();
        chk("t6_rst_pc", 128'(out_pc), 128'(32'h3000));
        chk("t6_rst_v", 128'(out_valid), 128'(0));
        chk("t6_rst_rdy", 128'(in_ready), 128'(1));
        reset = 1'b0;
        out_ready = 1'b1;
        drv(1'b0, 32'h3400, 5'd0, 1'b0);
        step();
        chk("t6_after_v", 128'(out_valid), 128'(0));
        chk("t6_after_rdy", 128'(in_ready), 128'(1));

        chk("sb_pops", 128'(pops), 128'(7));
        chk("sb_left", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
